pfu_pchinfo_buf: RTL

- Patch-info staging buffer directly upstream of the Pauli frame unit (PFU) controller.
- Accepts per-patch info words from the patch information unit (PIU) while no RUN_ESM is in flight.
- Groups the words into instructions, where the last word of each instruction is flagged.
- Drains one group in first-word-fall-through (FWFT) order during the PFU UPDATING state, and generates the stall, last-word and group-available indications the PFU controller consumes.

---
 rtl/pfu_pchinfo_buf.sv | 80 ++++++++
 1 files changed

// File: rtl/pfu_pchinfo_buf.sv
// pfu_pchinfo_buf: FWFT patch-info staging buffer with instruction-group tracking for the PFU
module pfu_pchinfo_buf #(
  parameter int PCHINFO_BW = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_BW    = 4,
  parameter int GRP_MAX    = 4,
  parameter int GRPCNT_BW  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [PCHINFO_BW-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [PCHINFO_BW-1:0] pop_data,
  output logic                  pchinfo_rdlast,
  output logic                  pchwr_stall,
  output logic                  grp_avail,
  output logic [ADDR_BW:0]      count,
  output logic [GRPCNT_BW-1:0]  grp_cnt,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf_err,
  output logic                  unf_err
);
  logic [PCHINFO_BW:0]   mem_q [DEPTH];
  logic [PCHINFO_BW:0]   mem_d [DEPTH];
  logic [ADDR_BW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BW:0]      count_q, count_d;
  logic [GRPCNT_BW-1:0]  grp_cnt_q, grp_cnt_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  acc_push, acc_pop, head_last;

  assign empty          = count_q == '0;
  assign full           = count_q == (ADDR_BW+1)'(DEPTH);
  assign pchwr_stall    = full | (grp_cnt_q == GRPCNT_BW'(GRP_MAX));
  assign grp_avail      = grp_cnt_q != '0;
  assign head_last      = mem_q[rd_ptr_q][PCHINFO_BW];
  assign pop_data       = mem_q[rd_ptr_q][PCHINFO_BW-1:0];
  assign pchinfo_rdlast = ~empty & head_last;
  assign count          = count_q;
  assign grp_cnt        = grp_cnt_q;
  assign ovf_err        = ovf_q;
  assign unf_err        = unf_q;
  assign acc_push       = push & ~pchwr_stall & ~flush;
  assign acc_pop        = pop & ~empty & ~flush;

  always_comb begin
    mem_d = mem_q;
    if (acc_push) mem_d[wr_ptr_q] = {push_last, push_data};
    wr_ptr_d  = flush ? '0 : wr_ptr_q + ADDR_BW'(acc_push);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + ADDR_BW'(acc_pop);
    count_d   = flush ? '0 : count_q + (ADDR_BW+1)'(acc_push) - (ADDR_BW+1)'(acc_pop);
    grp_cnt_d = flush ? '0 : grp_cnt_q + GRPCNT_BW'(acc_push & push_last)
                                       - GRPCNT_BW'(acc_pop & head_last);
    ovf_d     = ovf_q | (push & pchwr_stall & ~flush);
    unf_d     = unf_q | (pop & empty & ~flush);
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      grp_cnt_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      grp_cnt_q <= grp_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end
endmodule
